slc3_isdu_ctrl: RTL and testbench

// Instruction sequencing/decode unit for the SLC-3 datapath. It is a Moore FSM that drives every LD_*, Gate*, mux-select,

---
 rtl/slc3_ctrl_pkg.sv | 54 +++++
 rtl/slc3_mem_wait_cnt.sv | 28 ++
 rtl/slc3_isdu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_slc3_isdu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_ctrl_pkg.sv
// SLC-3 control unit shared types: state codes (as shown on the hex display),
// opcodes, and datapath select encodings.
package slc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_0    = 5'd0,
    S_1    = 5'd1,
    S_32   = 5'd2,
    S_33   = 5'd3,
    S_4    = 5'd4,
    S_5    = 5'd5,
    S_6    = 5'd6,
    S_7    = 5'd7,
    S_35   = 5'd8,
    S_9    = 5'd9,
    S_P1   = 5'd10,
    S_P2   = 5'd11,
    S_12   = 5'd12,
    S_16   = 5'd16,
    S_18   = 5'd18,
    S_20   = 5'd20,
    S_21   = 5'd21,
    S_22   = 5'd22,
    S_23   = 5'd23,
    S_25   = 5'd25,
    S_27   = 5'd27,
    S_HALT = 5'd31
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_ADDR = 2'b01;
  localparam logic [1:0] PC_BUS  = 2'b10;

  localparam logic [1:0] A2_ZERO = 2'b00;
  localparam logic [1:0] A2_S6   = 2'b01;
  localparam logic [1:0] A2_S9   = 2'b10;
  localparam logic [1:0] A2_S11  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

endpackage

// File: rtl/slc3_mem_wait_cnt.sv
// Memory-strobe hold counter: loaded on entry to a memory state,
// counts down to zero and reports done while at zero.
module slc3_mem_wait_cnt #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  output logic done
);

  localparam logic [1:0] INIT = 2'(MEM_WAIT - 1);

  logic [1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= 2'd0;
    end else if (load) begin
      cnt <= INIT;
    end else if (cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign done = (cnt == 2'd0);

endmodule

// File: rtl/slc3_isdu_ctrl.sv
// SLC-3 instruction sequencing/decode unit: Moore FSM driving every
// load enable, bus gate, mux select and memory strobe of the datapath.
module slc3_isdu_ctrl
  import slc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State_dbg
);

  state_t state, nxt;
  logic   ir5_q;
  logic   led_first;
  logic   wait_done;
  logic   wait_load;

  assign wait_load = (nxt != state) &&
                     (nxt == S_33 || nxt == S_25 || nxt == S_16);

  slc3_mem_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_HALT: if (Run) nxt = S_18;
      S_18:   nxt = S_33;
      S_33:   if (wait_done) nxt = S_35;
      S_35:   nxt = S_32;
      S_32: begin
        case (Opcode)
          OP_ADD:  nxt = S_1;
          OP_AND:  nxt = S_5;
          OP_NOT:  nxt = S_9;
          OP_BR:   nxt = S_0;
          OP_JMP:  nxt = S_12;
          OP_JSR:  nxt = S_4;
          OP_LDR:  nxt = S_6;
          OP_STR:  nxt = S_7;
          OP_PSE:  nxt = S_P1;
          default: nxt = S_18;
        endcase
      end
      S_1, S_5, S_9: nxt = S_18;
      S_0:    nxt = BEN ? S_22 : S_18;
      S_22, S_12, S_21, S_20, S_27: nxt = S_18;
      S_4:    nxt = IR_11 ? S_21 : S_20;
      S_6:    nxt = S_25;
      S_7:    nxt = S_23;
      S_25:   if (wait_done) nxt = S_27;
      S_23:   nxt = S_16;
      S_16:   if (wait_done) nxt = S_18;
      S_P1:   if (Continue) nxt = S_P2;
      S_P2:   if (!Continue) nxt = S_18;
      default: nxt = S_HALT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_HALT;
      ir5_q     <= 1'b0;
      led_first <= 1'b0;
    end else begin
      state     <= nxt;
      if (state == S_32) ir5_q <= IR_5;
      led_first <= (state != S_P1) && (nxt == S_P1);
    end
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PC_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALU_ADD;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (state)
      S_18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = PC_INC;
        LD_PC  = 1'b1;
      end
      S_33, S_25: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = wait_done;
      end
      S_35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_32: LD_BEN = 1'b1;
      S_1, S_5: begin
        ALUK    = (state == S_5) ? ALU_AND : ALU_ADD;
        SR2MUX  = ir5_q;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_9: begin
        ALUK    = ALU_NOT;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_22: begin
        ADDR2MUX = A2_S9;
        PCMUX    = PC_ADDR;
        LD_PC    = 1'b1;
      end
      S_12, S_20: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = A2_ZERO;
        PCMUX    = PC_ADDR;
        LD_PC    = 1'b1;
      end
      S_4: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_21: begin
        ADDR2MUX = A2_S11;
        PCMUX    = PC_ADDR;
        LD_PC    = 1'b1;
      end
      S_6, S_7: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = A2_S6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_23: begin
        SR1MUX  = 1'b1;
        ALUK    = ALU_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_16: Mem_WE = 1'b0;
      S_P1: LD_LED = led_first;
      default: ;
    endcase
  end

  assign State_dbg = state;

endmodule

// File: tb/tb_slc3_isdu_ctrl.sv
// Scoreboard bench for slc3_isdu_ctrl: stimulus pushes the expected
// state/controls each cycle, a monitor pops and compares on the falling edge.
module tb_slc3_isdu_ctrl;
  import slc3_ctrl_pkg::*;

  localparam int MW = 2;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben;
    logic ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic mio_en, mem_oe, mem_we;
  } ctl_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       c;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;
  logic [4:0] State_dbg;
  ctl_t act;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   step = 0;
  event sample_ev;

  always #5 Clk = ~Clk;

  slc3_isdu_ctrl #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .State_dbg(State_dbg)
  );

  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                MIO_EN, Mem_OE, Mem_WE};

  // Expected control word of each state, straight from the state table.
  function automatic ctl_t exp_ctl(state_t s, logic ir5, logic last,
                                   logic first);
    ctl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (s)
      S_18: begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      S_33, S_25: begin c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = last; end
      S_35: begin c.gate_mdr = 1; c.ld_ir = 1; end
      S_32: c.ld_ben = 1;
      S_1: begin
        c.sr2mux = ir5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
      end
      S_5: begin
        c.aluk = 2'b01; c.sr2mux = ir5; c.gate_alu = 1;
        c.ld_reg = 1; c.ld_cc = 1;
      end
      S_9: begin
        c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
      end
      S_22: begin c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
      S_12, S_20: begin
        c.addr1mux = 1; c.pcmux = 2'b01; c.ld_pc = 1;
      end
      S_4: begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      S_21: begin c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; end
      S_6, S_7: begin
        c.addr1mux = 1; c.addr2mux = 2'b01;
        c.gate_marmux = 1; c.ld_mar = 1;
      end
      S_27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S_23: begin
        c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1;
      end
      S_16: c.mem_we = 0;
      S_P1: c.ld_led = first;
      default: ;
    endcase
    return c;
  endfunction

  task automatic expect_st(input state_t s, input logic ir5 = 1'b0,
                           input logic last = 1'b0,
                           input logic first = 1'b0);
    exp_t e;
    @(posedge Clk);
    #1;
    e.st = s;
    e.c  = exp_ctl(s, ir5, last, first);
    q.push_back(e);
  endtask

  task automatic fetch(input logic [3:0] op);
    Opcode = op;
    for (int i = 0; i < MW; i++) expect_st(S_33, 1'b0, (i == MW - 1));
    expect_st(S_35);
    expect_st(S_32);
  endtask

  task automatic compare_one();
    exp_t e;
    e = q.pop_front();
    step++;
    n_chk++;
    if (State_dbg === e.st) n_pass++;
    else $display("FAIL step%0d state: got %0d want %0d",
                  step, State_dbg, e.st);
    n_chk++;
    if (act === e.c) n_pass++;
    else $display("FAIL step%0d ctl (st %0d): got %h want %h",
                  step, e.st, act, e.c);
  endtask

  initial begin : monitor
    forever begin
      @(negedge Clk or sample_ev);
      n_chk++;
      if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1)
        n_pass++;
      else $display("FAIL gate_onehot: got %b want at most one set",
                    {GatePC, GateMDR, GateALU, GateMARMUX});
      if (q.size() != 0) compare_one();
    end
  end

  initial begin : stim
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'h0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    expect_st(S_HALT);
    Reset = 1'b1;
    expect_st(S_HALT);
    Run = 1'b1;
    expect_st(S_18);
    Run = 1'b0;
    // ADD with immediate; IR_5 changes after decode and must be ignored
    IR_5 = 1'b1;
    fetch(OP_ADD);
    expect_st(S_1, 1'b1);
    IR_5 = 1'b0;
    expect_st(S_18);
    fetch(OP_AND);
    expect_st(S_5, 1'b0);
    expect_st(S_18);
    fetch(OP_NOT);
    expect_st(S_9);
    expect_st(S_18);
    BEN = 1'b0;
    fetch(OP_BR);
    expect_st(S_0);
    expect_st(S_18);
    BEN = 1'b1;
    fetch(OP_BR);
    expect_st(S_0);
    expect_st(S_22);
    expect_st(S_18);
    IR_11 = 1'b1;
    fetch(OP_JSR);
    expect_st(S_4);
    expect_st(S_21);
    expect_st(S_18);
    IR_11 = 1'b0;
    fetch(OP_JSR);
    expect_st(S_4);
    expect_st(S_20);
    expect_st(S_18);
    fetch(OP_JMP);
    expect_st(S_12);
    expect_st(S_18);
    fetch(OP_LDR);
    expect_st(S_6);
    for (int i = 0; i < MW; i++) expect_st(S_25, 1'b0, (i == MW - 1));
    expect_st(S_27);
    expect_st(S_18);
    fetch(OP_STR);
    expect_st(S_7);
    expect_st(S_23);
    for (int i = 0; i < MW; i++) expect_st(S_16);
    expect_st(S_18);
    fetch(4'b1111);
    expect_st(S_18);
    // pause: LED strobe on entry only, one advance per press
    fetch(OP_PSE);
    expect_st(S_P1, 1'b0, 1'b0, 1'b1);
    expect_st(S_P1);
    expect_st(S_P1);
    Continue = 1'b1;
    for (int i = 0; i < 10; i++) expect_st(S_P2);
    Continue = 1'b0;
    expect_st(S_18);
    expect_st(S_33, 1'b0, (MW == 1));
    // asynchronous reset in the middle of a store strobe
    Opcode = OP_STR;
    for (int i = 1; i < MW; i++) expect_st(S_33, 1'b0, (i == MW - 1));
    expect_st(S_35);
    expect_st(S_32);
    expect_st(S_7);
    expect_st(S_23);
    expect_st(S_16);
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    begin
      exp_t e;
      e.st = S_HALT;
      e.c  = exp_ctl(S_HALT, 1'b0, 1'b0, 1'b0);
      q.push_back(e);
    end
    ->sample_ev;
    expect_st(S_HALT);
    Reset = 1'b1;
    expect_st(S_HALT);
    @(negedge Clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d left want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
